// File: rtl/pipe_hazard_ctrl_pkg.sv
// pipe_hazard_ctrl_pkg: shared register/data widths and hazard-controller state encodings.
`ifndef PIPE_HAZARD_CTRL_DEFINES
`define PIPE_HAZARD_CTRL_DEFINES
`define RegFileAddr 4:0
`define DataBus 63:0
`define CtrlStateBus 1:0
`define RUN 2'b00
`define MEM_WAIT 2'b01
`define ABORT 2'b10
`endif
package pipe_hazard_ctrl_pkg;
  typedef logic [`RegFileAddr] reg_addr_t;
  typedef logic [`DataBus] data_t;
  typedef logic [`CtrlStateBus] ctrl_state_t;
  localparam logic [1:0] ST_RUN = `RUN;
  localparam logic [1:0] ST_MEM_WAIT = `MEM_WAIT;
  localparam logic [1:0] ST_ABORT = `ABORT;
endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: pipeline <-> hazard controller signals; STALL_CNT_EN adds the stall counters.
interface pipe_hazard_ctrl_if;
  import pipe_hazard_ctrl_pkg::*;
  reg_addr_t RdAddrExIn;
  logic MemReadExIn;
  reg_addr_t Rs1AddrIdIn;
  reg_addr_t Rs2AddrIdIn;
  logic Rs1ReadEnableIdIn;
  logic Rs2ReadEnableIdIn;
  logic MemReqMemIn;
  logic MemAckMemIn;
  logic BranchTakenExIn;
  logic StallPcOut;
  logic StallIfIdOut;
  logic StallIdExOut;
  logic StallExMemOut;
  logic BubbleIdExOut;
  logic FlushIfIdOut;
  logic FlushIdExOut;
  logic MemTimeoutOut;
  ctrl_state_t CtrlStateOut;
`ifdef STALL_CNT_EN
  data_t LoadUseCntOut;
  data_t MemWaitCntOut;
`endif
  modport master (
    output RdAddrExIn, MemReadExIn, Rs1AddrIdIn, Rs2AddrIdIn, Rs1ReadEnableIdIn, Rs2ReadEnableIdIn,
    output MemReqMemIn, MemAckMemIn, BranchTakenExIn,
    input StallPcOut, StallIfIdOut, StallIdExOut, StallExMemOut, BubbleIdExOut,
    input FlushIfIdOut, FlushIdExOut, MemTimeoutOut, CtrlStateOut
`ifdef STALL_CNT_EN
    , input LoadUseCntOut, MemWaitCntOut
`endif
  );
  modport slave (
    input RdAddrExIn, MemReadExIn, Rs1AddrIdIn, Rs2AddrIdIn, Rs1ReadEnableIdIn, Rs2ReadEnableIdIn,
    input MemReqMemIn, MemAckMemIn, BranchTakenExIn,
    output StallPcOut, StallIfIdOut, StallIdExOut, StallExMemOut, BubbleIdExOut,
    output FlushIfIdOut, FlushIdExOut, MemTimeoutOut, CtrlStateOut
`ifdef STALL_CNT_EN
    , output LoadUseCntOut, MemWaitCntOut
`endif
  );
endinterface

// File: rtl/pipe_hazard_ctrl_load_use_detect.sv
// load_use_detect: flags an ID-stage read of the register an EX-stage load is about to write.
module load_use_detect
  import pipe_hazard_ctrl_pkg::*;
(
  input  reg_addr_t rd_addr,
  input  logic      mem_read,
  input  reg_addr_t rs1_addr,
  input  logic      rs1_en,
  input  reg_addr_t rs2_addr,
  input  logic      rs2_en,
  output logic      hazard
);
  assign hazard = mem_read && (rd_addr != '0) &&
                  ((rs1_en && rs1_addr == rd_addr) || (rs2_en && rs2_addr == rd_addr));
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/bubble/flush control with data-memory wait FSM and timeout abort.
// STALL_CNT_EN adds free-running load-use and memory-wait stall counters.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255
) (
  input logic Clk,
  input logic Rst,
  pipe_hazard_ctrl_if.slave bus
);
  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);
  logic [1:0] state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic load_use, abort, mem_stall, live, bubble, flush;
  load_use_detect u_load_use_detect (
    .rd_addr  (bus.RdAddrExIn),
    .mem_read (bus.MemReadExIn),
    .rs1_addr (bus.Rs1AddrIdIn),
    .rs1_en   (bus.Rs1ReadEnableIdIn),
    .rs2_addr (bus.Rs2AddrIdIn),
    .rs2_en   (bus.Rs2ReadEnableIdIn),
    .hazard   (load_use)
  );
  // Priority: abort cycle, then memory stall, then redirect, then load-use.
  always_comb begin
    abort = state_q == ST_ABORT;
    mem_stall = bus.MemReqMemIn && !bus.MemAckMemIn && !abort;
    live = !mem_stall && !abort;
    bubble = live && load_use && !bus.BranchTakenExIn;
    flush = abort || (live && bus.BranchTakenExIn);
  end
  assign bus.StallPcOut = mem_stall || bubble;
  assign bus.StallIfIdOut = mem_stall || bubble;
  assign bus.StallIdExOut = mem_stall;
  assign bus.StallExMemOut = mem_stall;
  assign bus.BubbleIdExOut = bubble;
  assign bus.FlushIfIdOut = flush;
  assign bus.FlushIdExOut = flush;
  assign bus.MemTimeoutOut = abort;
  assign bus.CtrlStateOut = state_q;
  always_comb begin
    state_d = state_q;
    wait_cnt_d = wait_cnt_q;
    if (state_q == ST_RUN) begin
      if (mem_stall) begin
        state_d = ST_MEM_WAIT;
        wait_cnt_d = '0;
      end
    end else if (state_q == ST_MEM_WAIT) begin
      if (bus.MemAckMemIn) state_d = ST_RUN;
      else if (wait_cnt_q == WAIT_LAST) state_d = ST_ABORT;
      else wait_cnt_d = wait_cnt_q + 8'd1;
    end else begin
      state_d = ST_RUN;
    end
  end
  always_ff @(posedge Clk or negedge Rst)
    if (!Rst) begin
      state_q <= ST_RUN;
      wait_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
`ifdef STALL_CNT_EN
  data_t lu_cnt_q, lu_cnt_d, mw_cnt_q, mw_cnt_d;
  always_comb begin
    lu_cnt_d = lu_cnt_q + data_t'(bubble);
    mw_cnt_d = mw_cnt_q + data_t'(mem_stall);
  end
  always_ff @(posedge Clk or negedge Rst)
    if (!Rst) begin
      lu_cnt_q <= '0;
      mw_cnt_q <= '0;
    end else begin
      lu_cnt_q <= lu_cnt_d;
      mw_cnt_q <= mw_cnt_d;
    end
  assign bus.LoadUseCntOut = lu_cnt_q;
  assign bus.MemWaitCntOut = mw_cnt_q;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed and random checks of pipe_hazard_ctrl against a cycle-level reference model.
module tb_pipe_hazard_ctrl;
  localparam int TMO = 4;
  logic Clk = 1'b0;
  logic Rst;
  int total = 0;
  int bad = 0;
  int m_state = 0;
  int m_wait = 0;
  longint unsigned m_lu = 0;
  longint unsigned m_mw = 0;
  pipe_hazard_ctrl_if bus ();
  pipe_hazard_ctrl #(.MEM_TIMEOUT(TMO)) dut (.Clk(Clk), .Rst(Rst), .bus(bus));
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] outs();
    return {bus.StallPcOut, bus.StallIfIdOut, bus.StallIdExOut, bus.StallExMemOut, bus.BubbleIdExOut,
            bus.FlushIfIdOut, bus.FlushIdExOut, bus.MemTimeoutOut, bus.CtrlStateOut};
  endfunction

  task automatic check_cnt(input string tag);
`ifdef STALL_CNT_EN
    chk({tag, "_lucnt"}, bus.LoadUseCntOut, m_lu);
    chk({tag, "_mwcnt"}, bus.MemWaitCntOut, m_mw);
`else
    if (tag.len() < 0) $display("%s", tag);
`endif
  endtask

  // Predict this cycle's outputs from the rules, then advance the model across the next edge.
  task automatic check_model(input string tag);
    bit hz, ab, ms, bb, fl;
    logic [9:0] exp;
    hz = bus.MemReadExIn && bus.RdAddrExIn != 0 &&
         ((bus.Rs1ReadEnableIdIn && bus.Rs1AddrIdIn == bus.RdAddrExIn) ||
          (bus.Rs2ReadEnableIdIn && bus.Rs2AddrIdIn == bus.RdAddrExIn));
    ab = (m_state == 2);
    ms = bus.MemReqMemIn && !bus.MemAckMemIn && !ab;
    bb = hz && !bus.BranchTakenExIn && !ms && !ab;
    fl = ab || (bus.BranchTakenExIn && !ms);
    exp = {ms || bb, ms || bb, ms, ms, bb, fl, fl, ab, 2'(m_state)};
    chk(tag, 64'(outs()), 64'(exp));
    check_cnt(tag);
    m_lu += 64'(bb);
    m_mw += 64'(ms);
    if (ab) m_state = 0;
    else if (m_state == 1) begin
      if (bus.MemAckMemIn) m_state = 0;
      else begin
        m_wait++;
        if (m_wait == TMO) m_state = 2;
      end
    end else if (ms) begin
      m_state = 1;
      m_wait = 0;
    end
  endtask

  task automatic cyc(input string tag, input logic [4:0] rd, input logic mr, input logic [4:0] r1,
                     input logic e1, input logic [4:0] r2, input logic e2, input logic rq,
                     input logic ak, input logic br);
    @(posedge Clk);
    #1;
    bus.RdAddrExIn = rd;
    bus.MemReadExIn = mr;
    bus.Rs1AddrIdIn = r1;
    bus.Rs1ReadEnableIdIn = e1;
    bus.Rs2AddrIdIn = r2;
    bus.Rs2ReadEnableIdIn = e2;
    bus.MemReqMemIn = rq;
    bus.MemAckMemIn = ak;
    bus.BranchTakenExIn = br;
    @(negedge Clk);
    check_model(tag);
  endtask

  task automatic zero_inputs();
    bus.RdAddrExIn = '0;
    bus.MemReadExIn = 1'b0;
    bus.Rs1AddrIdIn = '0;
    bus.Rs1ReadEnableIdIn = 1'b0;
    bus.Rs2AddrIdIn = '0;
    bus.Rs2ReadEnableIdIn = 1'b0;
    bus.MemReqMemIn = 1'b0;
    bus.MemAckMemIn = 1'b0;
    bus.BranchTakenExIn = 1'b0;
  endtask

  initial begin
    Rst = 1'b0;
    zero_inputs();
    #3;
    chk("reset_outs", 64'(outs()), 64'd0);
    check_cnt("reset");
    @(posedge Clk);
    #1 Rst = 1'b1;
    cyc("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("lu_x5", 5, 1, 0, 0, 5, 1, 0, 0, 0);
    chk("lu_x5_stall", {bus.StallPcOut, bus.StallIfIdOut, bus.BubbleIdExOut}, 3'b111);
    cyc("lu_x5_next", 0, 0, 0, 0, 5, 1, 0, 0, 0);
    chk("lu_x5_once", {bus.StallPcOut, bus.StallIfIdOut, bus.BubbleIdExOut}, 3'b000);
    cyc("lu_x0", 0, 1, 0, 1, 0, 1, 0, 0, 0);
    chk("lu_x0_none", {bus.StallPcOut, bus.BubbleIdExOut}, 2'b00);
    cyc("lu_br", 7, 1, 7, 1, 0, 0, 0, 0, 1);
    chk("lu_br_flush", {bus.FlushIfIdOut, bus.FlushIdExOut, bus.BubbleIdExOut, bus.StallPcOut}, 4'b1100);
    cyc("mw1", 0, 0, 0, 0, 0, 0, 1, 0, 0);
    chk("mw1_stalls", {bus.StallPcOut, bus.StallIfIdOut, bus.StallIdExOut, bus.StallExMemOut}, 4'hf);
    cyc("mw2", 0, 0, 0, 0, 0, 0, 1, 0, 1);
    chk("mw2_state", bus.CtrlStateOut, 2'b01);
    chk("mw2_noflush", bus.FlushIfIdOut, 1'b0);
    cyc("mw3", 0, 0, 0, 0, 0, 0, 1, 0, 0);
    chk("mw3_state", bus.CtrlStateOut, 2'b01);
    cyc("mw_ack", 3, 1, 3, 1, 0, 0, 1, 1, 0);
    chk("mw_ack_drop", {bus.StallIdExOut, bus.StallExMemOut, bus.BubbleIdExOut}, 3'b001);
    cyc("mw_after", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("mw_after_run", bus.CtrlStateOut, 2'b00);
    cyc("tmo_run", 0, 0, 0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < TMO; i++) begin
      cyc("tmo_wait", 0, 0, 0, 0, 0, 0, 1, 0, 0);
      chk("tmo_wait_state", bus.CtrlStateOut, 2'b01);
    end
    cyc("tmo_abort", 0, 0, 0, 0, 0, 0, 1, 0, 0);
    chk("tmo_abort_outs", {bus.MemTimeoutOut, bus.FlushIfIdOut, bus.FlushIdExOut, bus.StallPcOut, bus.CtrlStateOut}, 6'b111010);
    cyc("tmo_back", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("tmo_back_run", {bus.MemTimeoutOut, bus.CtrlStateOut}, 3'b000);
    cyc("rw1", 0, 0, 0, 0, 0, 0, 1, 0, 0);
    cyc("rw2", 0, 0, 0, 0, 0, 0, 1, 0, 0);
    #2;
    Rst = 1'b0;
    zero_inputs();
    #1;
    m_state = 0;
    m_wait = 0;
    m_lu = 0;
    m_mw = 0;
    chk("rst_midwait", 64'(outs()), 64'd0);
    check_cnt("rst_midwait");
    @(posedge Clk);
    #1 Rst = 1'b1;
    repeat (400)
      cyc("rand", 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
          1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 5) == 0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
